// File: rtl/qdma_if.sv
// qdma_if: client-side transfer handshake between a disk datapath and qdma.
//   req    client -> qdma  transfer request, level, held until done
//   write  client -> qdma  1 = DATO (write memory), 0 = DATI (read memory)
//   addr   client -> qdma  22-bit word address (bit 0 ignored)
//   wdata  client -> qdma  write data
//   rdata  qdma -> client  read data, valid with done on DATI
//   done   qdma -> client  one-cycle completion pulse
//   nxm    qdma -> client  valid with done: no RRPLY before timeout
//   busy   qdma -> client  bus-master sequence in progress
interface qdma_if;
  logic        req;
  logic        write;
  logic [21:0] addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        done;
  logic        nxm;
  logic        busy;

  modport master (output req, write, addr, wdata,
                  input  rdata, done, nxm, busy);

  modport slave  (input  req, write, addr, wdata,
                  output rdata, done, nxm, busy);
endinterface

// File: rtl/qdma.sv
// qdma: QBUS DMA bus master for single-word DATI/DATO transfers.
// Arbitrates with DMR/DMG/SACK, runs one bus cycle per tenure, and
// reports completion (done) or non-existent memory (nxm).
//   qclk, init              clock, synchronous active-high reset
//   DALbe_L, DALtx, DALst   BDAL output enable / transmit / latch strobe
//   ZDAL, ZBS7, ZWTBT       bus address/data, I/O page, write/byte (tri-state)
//   TSYNC..TDMGO            bus control outputs
//   RSYNC, RRPLY, RDMGI     received bus controls (already synchronized)
//   clnt                    client transfer handshake (qdma_if.slave)
module qdma #(
  parameter int unsigned ADDR_SETUP  = 3,
  parameter int unsigned DATA_SETUP  = 2,
  parameter int unsigned NXM_TIMEOUT = 200
) (
  input  logic        qclk,
  input  logic        init,
  output logic        DALbe_L,
  output logic        DALtx,
  output logic        DALst,
  inout  wire  [21:0] ZDAL,
  inout  wire         ZBS7,
  inout  wire         ZWTBT,
  output logic        TSYNC,
  output logic        TDIN,
  output logic        TDOUT,
  output logic        TDMR,
  output logic        TSACK,
  output logic        TDMGO,
  input  logic        RSYNC,
  input  logic        RRPLY,
  input  logic        RDMGI,
  qdma_if.slave       clnt
);

  localparam int unsigned CW = $clog2(NXM_TIMEOUT + ADDR_SETUP + DATA_SETUP + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_REQ, S_WAITBUS, S_ADDR, S_DSETUP, S_DIN, S_XFER, S_TERM, S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            write_q;
  logic [21:0]     addr_q;
  logic [15:0]     wdata_q;
  logic [15:0]     rdata_q;
  logic            nxm_q;
  logic            done_q;
  logic            dmg_low_q;

  logic            timeout;
  logic [21:0]     dal_o;
  logic            bs7_o;
  logic            bs7_en;
  logic            wtbt_o;

  // Counter covers the whole time TDIN/TDOUT is asserted; for DATI the
  // DIN cycle already counts, so XFER is entered with the counter at 1.
  assign timeout = (state_q == S_XFER) && !RRPLY && (cnt_q == CW'(NXM_TIMEOUT - 1));

  always_ff @(posedge qclk) begin
    if (init) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      write_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      nxm_q     <= 1'b0;
      done_q    <= 1'b0;
      dmg_low_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= (state_q == S_DONE);
      // Grant is a rising RDMGI seen inside REQ: remember a low level first.
      dmg_low_q <= (state_q == S_REQ) && (dmg_low_q || !RDMGI);
      if (state_q == S_IDLE && clnt.req) begin
        write_q <= clnt.write;
        addr_q  <= clnt.addr & ~22'd1;
        wdata_q <= clnt.wdata;
        nxm_q   <= 1'b0;
      end
      if (state_q == S_XFER && RRPLY && !write_q) rdata_q <= ZDAL[15:0];
      if (timeout) nxm_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (clnt.req) state_d = S_REQ;
      end
      S_REQ: begin
        cnt_d = '0;
        if (RDMGI && dmg_low_q) state_d = S_WAITBUS;
      end
      S_WAITBUS: begin
        cnt_d = '0;
        if (!RSYNC && !RRPLY) state_d = S_ADDR;
      end
      S_ADDR: begin
        if (cnt_q == CW'(ADDR_SETUP)) begin
          state_d = write_q ? S_DSETUP : S_DIN;
          cnt_d   = '0;
        end
      end
      S_DSETUP: begin
        if (cnt_q == CW'(DATA_SETUP - 1)) begin
          state_d = S_XFER;
          cnt_d   = '0;
        end
      end
      S_DIN: begin
        state_d = S_XFER;
        cnt_d   = CW'(1);
      end
      S_XFER: begin
        if (RRPLY)        state_d = S_TERM;
        else if (timeout) state_d = S_DONE;
      end
      S_TERM: begin
        if (!RRPLY) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    TSYNC  = 1'b0;
    TDIN   = 1'b0;
    TDOUT  = 1'b0;
    TDMR   = 1'b0;
    TSACK  = 1'b0;
    TDMGO  = 1'b0;
    DALtx  = 1'b0;
    DALst  = 1'b0;
    dal_o  = {6'b0, wdata_q};
    bs7_o  = 1'b0;
    bs7_en = 1'b0;
    wtbt_o = 1'b0;
    case (state_q)
      S_IDLE:    TDMGO = RDMGI;
      S_REQ:     TDMR  = 1'b1;
      S_WAITBUS: TSACK = 1'b1;
      S_ADDR: begin
        // Address is held one more cycle after TSYNC rises.
        TSACK  = 1'b1;
        TSYNC  = (cnt_q == CW'(ADDR_SETUP));
        DALtx  = 1'b1;
        DALst  = (cnt_q == '0);
        dal_o  = addr_q;
        bs7_en = 1'b1;
        bs7_o  = &addr_q[21:13];
        wtbt_o = write_q;
      end
      S_DSETUP: begin
        TSACK = 1'b1;
        TSYNC = 1'b1;
        DALtx = 1'b1;
        DALst = (cnt_q == '0);
      end
      S_DIN: begin
        TSACK = 1'b1;
        TSYNC = 1'b1;
        TDIN  = 1'b1;
      end
      S_XFER: begin
        TSACK = 1'b1;
        TSYNC = 1'b1;
        TDIN  = !write_q;
        TDOUT = write_q;
        DALtx = write_q;
      end
      S_TERM: begin
        TSACK = 1'b1;
        TSYNC = 1'b1;
        DALtx = write_q;
      end
      S_DONE:  TSACK = 1'b1;
      default: ;
    endcase
  end

  assign DALbe_L = ~DALtx;
  assign ZDAL    = DALtx  ? dal_o  : 'z;
  assign ZBS7    = bs7_en ? bs7_o  : 1'bz;
  assign ZWTBT   = DALtx  ? wtbt_o : 1'bz;

  assign clnt.rdata = rdata_q;
  assign clnt.done  = done_q;
  assign clnt.nxm   = done_q & nxm_q;
  assign clnt.busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_qdma.sv
module tb_qdma;
  logic qclk = 1'b0;
  logic init = 1'b1;
  logic DALbe_L, DALtx, DALst, TSYNC, TDIN, TDOUT, TDMR, TSACK, TDMGO;
  logic RSYNC = 1'b0, RRPLY = 1'b0, RDMGI = 1'b0;
  wire [21:0] ZDAL;
  wire        ZBS7, ZWTBT;
  logic       tb_drv = 1'b0;
  logic [15:0] tb_d = '0;

  assign ZDAL = tb_drv ? {6'b0, tb_d} : 'z;

  qdma_if cif();

  int tests = 0;
  int errors = 0;

  typedef struct { bit is_rd; logic [15:0] rdata; logic nxm; } exp_t;
  exp_t sb[$];

  qdma #(.ADDR_SETUP(3), .DATA_SETUP(2), .NXM_TIMEOUT(200)) dut (
    .qclk(qclk), .init(init),
    .DALbe_L(DALbe_L), .DALtx(DALtx), .DALst(DALst),
    .ZDAL(ZDAL), .ZBS7(ZBS7), .ZWTBT(ZWTBT),
    .TSYNC(TSYNC), .TDIN(TDIN), .TDOUT(TDOUT), .TDMR(TDMR), .TSACK(TSACK), .TDMGO(TDMGO),
    .RSYNC(RSYNC), .RRPLY(RRPLY), .RDMGI(RDMGI),
    .clnt(cif)
  );

  always #5 qclk = ~qclk;

  task automatic tick();
    @(posedge qclk);
    #1;
  endtask

  // Bus-grant sequence: wait for DMR, show RDMGI low one cycle, then raise it.
  task automatic arbitrate(output bit ok);
    int n;
    RDMGI = 1'b0;
    n = 0;
    while (!TDMR && n < 10) begin tick(); n++; end
    tick();
    RDMGI = 1'b1;
    n = 0;
    while (!TSACK && n < 10) begin tick(); n++; end
    RDMGI = 1'b0;
    ok = TSACK;
  endtask

  // Slave side: reply dly cycles after TDIN/TDOUT, then finish the cycle.
  task automatic slave_reply(input logic [15:0] d, input int dly, output bit ok);
    int n;
    ok = 1'b1;
    n = 0;
    while (!(TDIN || TDOUT) && n < 50) begin tick(); n++; end
    if (!(TDIN || TDOUT)) ok = 1'b0;
    repeat (dly) tick();
    tb_d = d;
    tb_drv = TDIN;
    RRPLY = 1'b1;
    n = 0;
    while ((TDIN || TDOUT) && n < 50) begin tick(); n++; end
    if (TDIN || TDOUT) ok = 1'b0;
    RRPLY = 1'b0;
    tb_drv = 1'b0;
    n = 0;
    while (TSYNC && n < 50) begin tick(); n++; end
    if (TSYNC) ok = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    init = 1'b1;
    cif.req = 1'b0; cif.write = 1'b0; cif.addr = '0; cif.wdata = '0;
    tick(); tick();
    init = 1'b0;
    tick();
    tests++;
    if ({TSYNC, TDIN, TDOUT, TDMR, TSACK} !== 5'b0) begin
      errors++; $display("FAIL rst_tlines: got %b want 00000", {TSYNC, TDIN, TDOUT, TDMR, TSACK});
    end
    tests++;
    if ({cif.done, cif.nxm, cif.busy} !== 3'b0) begin
      errors++; $display("FAIL rst_client: got done/nxm/busy=%b want 000", {cif.done, cif.nxm, cif.busy});
    end
    tests++;
    if ({DALbe_L, DALtx, DALst} !== 3'b100) begin
      errors++; $display("FAIL rst_dal: got be_L/tx/st=%b want 100", {DALbe_L, DALtx, DALst});
    end
    tests++;
    if (cif.rdata !== 16'h0) begin
      errors++; $display("FAIL rst_rdata: got %h want 0000", cif.rdata);
    end
    RDMGI = 1'b1; #1;
    tests++;
    if (TDMGO !== 1'b1) begin errors++; $display("FAIL idle_dmgo_hi: got %b want 1", TDMGO); end
    RDMGI = 1'b0; #1;
    tests++;
    if (TDMGO !== 1'b0) begin errors++; $display("FAIL idle_dmgo_lo: got %b want 0", TDMGO); end
  endtask

  task automatic test_dato();
    bit ok;
    int acnt = 0, dcnt = 0, nst = 0, bad = 0;
    exp_t e;
    logic [21:0] a = 22'o0001000;
    logic [15:0] d = 16'o123456;
    cif.req = 1'b1; cif.write = 1'b1; cif.addr = a; cif.wdata = d;
    sb.push_back('{1'b0, 16'h0, 1'b0});
    arbitrate(ok);
    tests++;
    if (!ok) begin errors++; $display("FAIL dato_grant: got TSACK=%b want 1", TSACK); end
    for (int i = 0; i < 20 && !TSYNC; i++) begin
      if (DALtx && ZDAL == a) begin
        acnt++;
        if (ZWTBT !== 1'b1 || ZBS7 !== 1'b0) bad++;
      end
      if (DALst) nst++;
      tick();
    end
    tests++;
    if (acnt != 3) begin errors++; $display("FAIL dato_addr_setup: got %0d cycles want 3", acnt); end
    tests++;
    if (bad != 0) begin errors++; $display("FAIL dato_addr_qual: got %0d bad WTBT/BS7 cycles want 0", bad); end
    for (int i = 0; i < 20 && !TDOUT; i++) begin
      if (DALtx && ZDAL == {6'b0, d} && ZWTBT === 1'b0) dcnt++;
      if (DALst) nst++;
      tick();
    end
    tests++;
    if (dcnt != 2) begin errors++; $display("FAIL dato_data_setup: got %0d cycles want 2", dcnt); end
    tests++;
    if (nst != 2) begin errors++; $display("FAIL dato_dalst: got %0d pulses want 2", nst); end
    slave_reply(16'h0, 4, ok);
    tests++;
    if (!ok || cif.done !== 1'b1) begin
      errors++; $display("FAIL dato_done: got ok=%b done=%b want 1/1", ok, cif.done);
    end
    cif.req = 1'b0;
    tests++;
    if (sb.size() == 0) begin errors++; $display("FAIL dato_sb: got empty scoreboard want entry"); end
    else begin
      e = sb.pop_front();
      if (cif.nxm !== e.nxm) begin errors++; $display("FAIL dato_nxm: got %b want %b", cif.nxm, e.nxm); end
    end
    tests++;
    if (TSACK !== 1'b0 || cif.busy !== 1'b0) begin
      errors++; $display("FAIL dato_release: got TSACK=%b busy=%b want 0/0", TSACK, cif.busy);
    end
    tick();
    tests++;
    if (cif.done !== 1'b0) begin errors++; $display("FAIL dato_done_pulse: got %b want 0", cif.done); end
  endtask

  task automatic test_dati();
    bit ok;
    int acnt = 0, bad = 0, n = 0;
    exp_t e;
    logic [15:0] d = 16'o052525;
    cif.req = 1'b1; cif.write = 1'b0; cif.addr = 22'o17777700; cif.wdata = 16'hffff;
    sb.push_back('{1'b1, d, 1'b0});
    arbitrate(ok);
    tests++;
    if (!ok) begin errors++; $display("FAIL dati_grant: got TSACK=%b want 1", TSACK); end
    for (int i = 0; i < 20 && !TSYNC; i++) begin
      if (DALtx) begin acnt++; if (ZBS7 !== 1'b1) bad++; end
      tick();
    end
    tests++;
    if (acnt != 3 || bad != 0) begin
      errors++; $display("FAIL dati_bs7: got %0d addr cycles %0d without BS7 want 3/0", acnt, bad);
    end
    while (!TDIN && n < 20) begin tick(); n++; end
    tests++;
    if (TDIN !== 1'b1 || DALtx !== 1'b0 || DALbe_L !== 1'b1) begin
      errors++; $display("FAIL dati_tdin: got TDIN=%b DALtx=%b DALbe_L=%b want 1/0/1", TDIN, DALtx, DALbe_L);
    end
    slave_reply(d, 2, ok);
    tests++;
    if (!ok || cif.done !== 1'b1) begin
      errors++; $display("FAIL dati_done: got ok=%b done=%b want 1/1", ok, cif.done);
    end
    cif.req = 1'b0;
    tests++;
    if (sb.size() == 0) begin errors++; $display("FAIL dati_sb: got empty scoreboard want entry"); end
    else begin
      e = sb.pop_front();
      if (cif.nxm !== e.nxm || (e.is_rd && cif.rdata !== e.rdata)) begin
        errors++; $display("FAIL dati_result: got nxm=%b rdata=%o want nxm=%b rdata=%o", cif.nxm, cif.rdata, e.nxm, e.rdata);
      end
    end
    tick();
  endtask

  task automatic test_nxm();
    bit ok;
    int n = 0;
    exp_t e;
    cif.req = 1'b1; cif.write = 1'b0; cif.addr = 22'o0000100;
    sb.push_back('{1'b0, 16'h0, 1'b1});
    arbitrate(ok);
    while (!TDIN && n < 30) begin tick(); n++; end
    tests++;
    if (TDIN !== 1'b1) begin errors++; $display("FAIL nxm_tdin: got %b want 1", TDIN); end
    n = 0;
    while (TDIN && n < 300) begin tick(); n++; end
    tests++;
    if (n != 200) begin errors++; $display("FAIL nxm_timeout: got TDIN high %0d cycles want 200", n); end
    tests++;
    if (TSYNC !== 1'b0) begin errors++; $display("FAIL nxm_tsync: got %b want 0", TSYNC); end
    tick();
    cif.req = 1'b0;
    tests++;
    if (cif.done !== 1'b1) begin errors++; $display("FAIL nxm_done: got %b want 1", cif.done); end
    else if (sb.size() == 0) begin errors++; $display("FAIL nxm_sb: got empty scoreboard want entry"); end
    else begin
      e = sb.pop_front();
      if (cif.nxm !== e.nxm) begin errors++; $display("FAIL nxm_flag: got %b want %b", cif.nxm, e.nxm); end
    end
    tests++;
    if ({TSYNC, TSACK, cif.busy} !== 3'b000) begin
      errors++; $display("FAIL nxm_release: got TSYNC/TSACK/busy=%b want 000", {TSYNC, TSACK, cif.busy});
    end
    tick();
  endtask

  task automatic test_grant();
    int bad = 0;
    RDMGI = 1'b1;
    cif.req = 1'b1; cif.write = 1'b0; cif.addr = 22'o0000200;
    tick();
    tests++;
    if (TDMGO !== 1'b0 || TDMR !== 1'b1) begin
      errors++; $display("FAIL grant_req: got TDMGO=%b TDMR=%b want 0/1", TDMGO, TDMR);
    end
    repeat (5) begin tick(); if (TSACK !== 1'b0 || TDMGO !== 1'b0) bad++; end
    tests++;
    if (bad != 0) begin errors++; $display("FAIL grant_stale: got %0d captured cycles want 0", bad); end
    RDMGI = 1'b0;
    tick();
    tests++;
    if (TSACK !== 1'b0) begin errors++; $display("FAIL grant_low: got TSACK=%b want 0", TSACK); end
    RDMGI = 1'b1;
    tick();
    tests++;
    if (TSACK !== 1'b1) begin errors++; $display("FAIL grant_edge: got TSACK=%b want 1", TSACK); end
    init = 1'b1; cif.req = 1'b0; RDMGI = 1'b0;
    tick();
    init = 1'b0;
    tick();
  endtask

  task automatic test_waitbus();
    bit ok;
    int bad = 0;
    exp_t e;
    RSYNC = 1'b1;
    cif.req = 1'b1; cif.write = 1'b1; cif.addr = 22'o0002000; cif.wdata = 16'h1234;
    sb.push_back('{1'b0, 16'h0, 1'b0});
    arbitrate(ok);
    repeat (10) begin
      if (!(TSACK === 1'b1 && TSYNC === 1'b0 && DALtx === 1'b0)) bad++;
      tick();
    end
    tests++;
    if (bad != 0) begin errors++; $display("FAIL waitbus_hold: got %0d bad cycles want 0", bad); end
    RSYNC = 1'b0;
    tick();
    tests++;
    if (DALtx !== 1'b1 || DALst !== 1'b1) begin
      errors++; $display("FAIL waitbus_addr: got DALtx=%b DALst=%b want 1/1", DALtx, DALst);
    end
    slave_reply(16'h0, 1, ok);
    cif.req = 1'b0;
    tests++;
    if (!ok || cif.done !== 1'b1 || sb.size() == 0) begin
      errors++; $display("FAIL waitbus_done: got ok=%b done=%b want 1/1", ok, cif.done);
    end else begin
      e = sb.pop_front();
      if (cif.nxm !== e.nxm) begin errors++; $display("FAIL waitbus_nxm: got %b want %b", cif.nxm, e.nxm); end
    end
    tick();
  endtask

  task automatic test_init_abort();
    bit ok;
    int n = 0;
    cif.req = 1'b1; cif.write = 1'b0; cif.addr = 22'o0003000;
    arbitrate(ok);
    while (!TDIN && n < 30) begin tick(); n++; end
    tick(); tick(); tick();
    tests++;
    if (TDIN !== 1'b1) begin errors++; $display("FAIL abort_xfer: got TDIN=%b want 1", TDIN); end
    init = 1'b1; cif.req = 1'b0;
    tick();
    tests++;
    if ({TSYNC, TDIN, TDOUT, TDMR, TSACK, DALtx, DALbe_L, cif.busy, cif.done} !== 9'b000000100) begin
      errors++; $display("FAIL abort_release: got %b want 000000100",
                         {TSYNC, TDIN, TDOUT, TDMR, TSACK, DALtx, DALbe_L, cif.busy, cif.done});
    end
    init = 1'b0;
    n = 0;
    repeat (5) begin tick(); if (cif.done) n++; end
    tests++;
    if (n != 0) begin errors++; $display("FAIL abort_nodone: got %0d done pulses want 0", n); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    exp_t e;
    cif.req = 1'b1; cif.write = 1'b1; cif.addr = 22'o0004000; cif.wdata = 16'hbeef;
    sb.push_back('{1'b0, 16'h0, 1'b0});
    sb.push_back('{1'b0, 16'h0, 1'b0});
    for (int k = 0; k < 2; k++) begin
      arbitrate(ok);
      slave_reply(16'h0, 1, ok);
      if (k == 1) cif.req = 1'b0;
      tests++;
      if (!ok || cif.done !== 1'b1 || cif.busy !== 1'b0 || sb.size() == 0) begin
        errors++; $display("FAIL b2b_done%0d: got ok=%b done=%b busy=%b want 1/1/0", k, ok, cif.done, cif.busy);
      end else begin
        e = sb.pop_front();
        if (cif.nxm !== e.nxm) begin errors++; $display("FAIL b2b_nxm%0d: got %b want %b", k, cif.nxm, e.nxm); end
      end
      tick();
      if (k == 0) begin
        tests++;
        if (TDMR !== 1'b1 || cif.busy !== 1'b1) begin
          errors++; $display("FAIL b2b_rearb: got TDMR=%b busy=%b want 1/1", TDMR, cif.busy);
        end
      end
    end
    tests++;
    if (sb.size() != 0 || cif.busy !== 1'b0) begin
      errors++; $display("FAIL b2b_end: got %0d pending busy=%b want 0/0", sb.size(), cif.busy);
    end
  endtask

  initial begin
    test_reset();
    test_dato();
    test_dati();
    test_nxm();
    test_grant();
    test_waitbus();
    test_init_abort();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: got no completion want finish before 500000");
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/qdma.md
Name: qdma

Overview:
- QBUS DMA bus master (initiator) for the QSIC disk controllers; it is the counterpart of the qreg slave interface.
- A client, e.g. the RK/RL disk datapath, requests one word transfer: DATI (read from memory) or DATO (write to memory) at a 22-bit address.
- qdma arbitrates for the bus (DMR/DMG/SACK), runs the cycle, and reports completion or non-existent memory.
- The top level muxes its DAL controls with qreg's, selecting qdma whenever busy=1.

Parameters:
- ADDR_SETUP, 3, qclk cycles the address is driven before TSYNC asserts (150 ns at 20 MHz).
- DATA_SETUP, 2, qclk cycles write data is driven before TDOUT asserts.
- NXM_TIMEOUT, 200, qclk cycles to wait for RRPLY after TDIN/TDOUT before declaring NXM (10 us).

Ports:
- qclk  in  1  QBUS-domain clock, 20 MHz
- init  in  1  synchronous active-high reset
- DALbe_L  out  1  enable BDAL output onto bus, active low
- DALtx  out  1  enable BDAL level-shifter transmit
- DALst  out  1  strobe output value into BDAL latch
- ZDAL  inout  22  bus address/data
- ZBS7  inout  1  I/O page select
- ZWTBT  inout  1  write/byte
- TSYNC  out  1  drive BSYNC
- TDIN  out  1  drive BDIN
- TDOUT  out  1  drive BDOUT
- TDMR  out  1  drive BDMR
- TSACK  out  1  drive BSACK
- TDMGO  out  1  DMG daisy-chain out
- RSYNC  in  1  received BSYNC
- RRPLY  in  1  received BRPLY
- RDMGI  in  1  DMG daisy-chain in
- req  in  1  client transfer request, level, held until done
- write  in  1  1=DATO, 0=DATI; sampled with req
- addr  in  22  word address; bit 0 ignored, forced 0
- wdata  in  16  write data
- rdata  out  16  read data, valid when done=1 and write=0
- done  out  1  one-cycle completion pulse
- nxm  out  1  valid with done: 1 = timeout, no RRPLY
- busy  out  1  1 from leaving IDLE until return to IDLE

Behaviour:
- All R* inputs are already synchronized to qclk by the top level.
- Reset (init=1, sampled on a qclk edge) forces IDLE on the next edge. All T* outputs, done, nxm and busy are 0. DALbe_L=1, DALtx=0, DALst=0. ZDAL, ZBS7 and ZWTBT are Z. rdata=0. TDMGO follows RDMGI combinationally in IDLE.
- init mid-operation abandons the cycle: every bus line is released on the next edge and no done pulse is issued.
- ZDAL, ZBS7 and ZWTBT are driven only when DALtx=1; otherwise they are Z.
- DALst pulses for one cycle on the first cycle of each new output value (the address, then the write data).

State machine:
- IDLE: busy=0 and TDMGO=RDMGI. On req=1, latch write, addr and wdata, then go to REQ.
- REQ: TDMR=1 and TDMGO=0. Only a 0->1 edge of RDMGI observed while in REQ is a grant. An RDMGI already high on entry belongs downstream and is not captured. On the grant, go to WAITBUS.
- WAITBUS: TSACK=1, TDMR=0, TDMGO=0. When RSYNC=0 and RRPLY=0, go to ADDR.
- ADDR:
  - Drive ZDAL=addr with bit 0 forced 0, DALtx=1 and DALbe_L=0.
  - ZBS7=1 iff addr[21:13] is all ones. ZWTBT=write.
  - After ADDR_SETUP cycles, assert TSYNC (held until DONE).
  - For DATI, go to DIN. For DATO, go to DSETUP.
- DSETUP:
  - ZDAL={6'b0,wdata} and ZWTBT=0 (word transfers only). ZBS7 is no longer driven.
  - After DATA_SETUP cycles, go to XFER with TDOUT=1.
- DIN:
  - Stop driving DAL: DALtx=0 and DALbe_L=1.
  - TDIN=1, then go to XFER.
- XFER:
  - Wait for RRPLY=1 with a counter starting at 0. On DATI, capture rdata=ZDAL[15:0] on the cycle RRPLY is first seen.
  - Then negate TDIN/TDOUT and go to TERM.
  - If the counter reaches NXM_TIMEOUT, set the nxm flag, negate TDIN/TDOUT and go to DONE.
- TERM: wait for RRPLY=0, then go to DONE.
- DONE:
  - Negate TSYNC and release DAL.
  - Next cycle: negate TSACK, pulse done (with nxm valid), and return to IDLE.
- When DATO and RRPLY coincide with a timeout expiry, RRPLY wins and nxm=0.
- The client must drop req after done. If req is still high in IDLE, a new transfer starts, so req held high performs back-to-back transfers, re-arbitrating each word.
- One word per bus tenure; no block mode.

Test Plan:
- DATO addr=22'o0001000, wdata=16'o123456, RDMGI pulses, slave replies 4 cycles after TDOUT -> required response:
  - ZDAL carries the address for 3 cycles before TSYNC, with ZWTBT=1 and ZBS7=0.
  - The data is driven 2 cycles before TDOUT.
  - done=1 and nxm=0 one cycle after TSYNC drops.
- DATI addr=22'o17777700, slave drives 16'o052525 with RRPLY -> required response: ZBS7=1 during the address phase, TDIN asserted, rdata=16'o052525 at done, nxm=0.
- No RRPLY after TDIN -> required response: TDIN drops exactly 200 cycles after assertion, then done=1 with nxm=1, TSYNC and TSACK released, busy=0.
- Grant arbitration:
  - RDMGI already high when req rises -> required response: not captured, TDMGO=0, TSACK stays 0 until RDMGI falls and re-rises.
  - In IDLE, TDMGO mirrors RDMGI.
- WAITBUS with RSYNC held 1 for 10 cycles -> required response: TSACK=1 and TSYNC=0 throughout; ADDR is entered only after RSYNC=0.
- init asserted during XFER -> required response: next edge has all T* at 0, DALtx=0, DALbe_L=1, busy=0, and no done pulse.
